// File: rtl/cn_counter_pkg.sv
// Shared definitions for the CN-cell counter: per-bit op encoding and a
// width helper used when validating the modulus.
package cn_counter_pkg;

    typedef enum logic [1:0] {
        CN_HOLD   = 2'b00,
        CN_CLEAR  = 2'b01,
        CN_TOGGLE = 2'b10,
        CN_SET    = 2'b11
    } cn_op_e;

    // Number of bits needed to hold the values 0..v-1.
    function automatic int cn_clog2(input longint unsigned v);
        longint unsigned x;
        int r;
        x = (v > 0) ? v - 1 : 0;
        r = 0;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cn_counter_if.sv
// Control/status bundle of the CN counter; master drives controls, slave is
// the counter itself.
interface cn_counter_if #(
    parameter int WIDTH = 8
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic             ovf_clr;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (
        output clr, load, load_val, en, up, ovf_clr,
        input  q, tc, ovf
    );

    modport slave (
        input  clr, load, load_val, en, up, ovf_clr,
        output q, tc, ovf
    );
endinterface

// File: rtl/cn_cell.sv
// Single CN storage bit: hold, clear, toggle or set on each rising clock edge.
module cn_cell
    import cn_counter_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  cn_op_e op,
    output logic   q
);

    logic q_q;
    logic q_d;

    // NOTE: every path assigns q_d, so no latch is inferred.
    always_comb begin
        q_d = q_q;
        unique case (op)
            CN_HOLD:   q_d = q_q;
            CN_CLEAR:  q_d = 1'b0;
            CN_TOGGLE: q_d = ~q_q;
            CN_SET:    q_d = 1'b1;
            default:   q_d = q_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= 1'b0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/cn_counter.sv
// Up/down counter with wrap or saturate, parallel load with clamp, terminal
// count and sticky overflow, built from per-bit CN cells without an adder.
module cn_counter
    import cn_counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = longint'(1) << WIDTH,
    parameter bit              SATURATE = 1'b0
) (
    input logic      clk,
    input logic      rst_n,
    cn_counter_if.slave bus
);

    if (MODULUS < 2 || cn_clog2(MODULUS) > WIDTH) begin : g_bad_modulus
        $error("cn_counter: MODULUS must lie in 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] inc_t;
    logic [WIDTH-1:0] dec_t;
    logic [WIDTH-1:0] load_tgt;
    logic             at_max;
    logic             at_zero;
    logic             evt;
    logic             ovf_q;
    logic             ovf_d;
    cn_op_e           ops [WIDTH];

    // Bit i toggles on increment when all lower bits are 1, on decrement when all are 0.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        if (i == 0) begin : g_lsb
            assign inc_t[i] = 1'b1;
            assign dec_t[i] = 1'b1;
        end else begin : g_upper
            assign inc_t[i] = &q[i-1:0];
            assign dec_t[i] = ~|q[i-1:0];
        end
    end

    assign at_max   = (q == MAX_Q);
    assign at_zero  = (q == '0);
    assign load_tgt = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;

    always_comb begin
        evt = 1'b0;
        for (int i = 0; i < WIDTH; i++) ops[i] = CN_HOLD;

        if (bus.clr) begin
            for (int i = 0; i < WIDTH; i++) ops[i] = CN_CLEAR;
        end else if (bus.load) begin
            for (int i = 0; i < WIDTH; i++) ops[i] = load_tgt[i] ? CN_SET : CN_CLEAR;
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_max) begin
                    evt = 1'b1;
                    if (!SATURATE)
                        for (int i = 0; i < WIDTH; i++) ops[i] = CN_CLEAR;
                end else begin
                    for (int i = 0; i < WIDTH; i++) ops[i] = inc_t[i] ? CN_TOGGLE : CN_HOLD;
                end
            end else begin
                if (at_zero) begin
                    evt = 1'b1;
                    if (!SATURATE)
                        for (int i = 0; i < WIDTH; i++) ops[i] = MAX_Q[i] ? CN_SET : CN_CLEAR;
                end else begin
                    for (int i = 0; i < WIDTH; i++) ops[i] = dec_t[i] ? CN_TOGGLE : CN_HOLD;
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        cn_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .op    (ops[i]),
            .q     (q[i])
        );
    end

    // A new event outranks a simultaneous clear request.
    assign ovf_d = evt | (ovf_q & ~bus.ovf_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign bus.q   = q;
    assign bus.tc  = bus.up ? at_max : at_zero;
    assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_cn_counter.sv
// Self-checking bench: three counter configurations checked against an
// arithmetic reference model with directed and random stimulus.
module tb_cn_counter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cn_counter_if #(.WIDTH(4)) ia ();
    cn_counter_if #(.WIDTH(4)) ib ();
    cn_counter_if #(.WIDTH(8)) ic ();

    cn_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    cn_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    cn_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    int n_checks = 0;
    int n_fail   = 0;
    int mq   [3];
    bit movf [3];
    int nq   [3];
    bit novf [3];

    function automatic int mod_of(input int k);
        return (k == 2) ? 256 : 10;
    endfunction

    function automatic bit sat_of(input int k);
        return (k == 1);
    endfunction

    function automatic void model_step(input int k, input logic clr, input logic load, input int lv,
                                       input logic en, input logic up, input logic ovf_clr);
        int m;
        int q;
        bit ev;
        m  = mod_of(k);
        q  = mq[k];
        ev = 1'b0;
        if (clr) q = 0;
        else if (load) q = (lv >= m) ? m - 1 : lv;
        else if (en && up) begin
            if (q == m - 1) begin ev = 1'b1; q = sat_of(k) ? q : 0; end
            else q = q + 1;
        end else if (en) begin
            if (q == 0) begin ev = 1'b1; q = sat_of(k) ? 0 : m - 1; end
            else q = q - 1;
        end
        nq[k]   = q;
        novf[k] = ev || (movf[k] && !ovf_clr);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare(input int k, input logic [31:0] q, input logic tc, input logic ovf, input logic up);
        bit exp_tc;
        exp_tc = up ? (mq[k] == mod_of(k) - 1) : (mq[k] == 0);
        check($sformatf("dut%0d_q", k), q, 32'(mq[k]));
        check($sformatf("dut%0d_tc", k), 32'(tc), 32'(exp_tc));
        check($sformatf("dut%0d_ovf", k), 32'(ovf), 32'(movf[k]));
    endtask

    task automatic tick();
        model_step(0, ia.clr, ia.load, int'(ia.load_val), ia.en, ia.up, ia.ovf_clr);
        model_step(1, ib.clr, ib.load, int'(ib.load_val), ib.en, ib.up, ib.ovf_clr);
        model_step(2, ic.clr, ic.load, int'(ic.load_val), ic.en, ic.up, ic.ovf_clr);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            mq[k]   = nq[k];
            movf[k] = novf[k];
        end
        #1;
        compare(0, 32'(ia.q), ia.tc, ia.ovf, ia.up);
        compare(1, 32'(ib.q), ib.tc, ib.ovf, ib.up);
        compare(2, 32'(ic.q), ic.tc, ic.ovf, ic.up);
    endtask

    task automatic idle_all();
        ia.clr = 0; ia.load = 0; ia.load_val = '0; ia.en = 0; ia.up = 1; ia.ovf_clr = 0;
        ib.clr = 0; ib.load = 0; ib.load_val = '0; ib.en = 0; ib.up = 1; ib.ovf_clr = 0;
        ic.clr = 0; ic.load = 0; ic.load_val = '0; ic.en = 0; ic.up = 1; ic.ovf_clr = 0;
    endtask

    task automatic reset_models();
        for (int k = 0; k < 3; k++) begin
            mq[k]   = 0;
            movf[k] = 1'b0;
        end
    endtask

    initial begin
        idle_all();
        reset_models();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_q_a", 32'(ia.q), 32'd0);
        check("reset_ovf_c", 32'(ic.ovf), 32'd0);

        // Reset asserted between edges while counting.
        ia.load = 1; ia.load_val = 4'd5;
        ic.load = 1; ic.load_val = 8'd255;
        tick();
        check("pre_reset_q_a", 32'(ia.q), 32'd5);
        idle_all();
        ia.en = 1; ic.en = 1;
        ic.load = 0;
        ia.en = 0;
        tick();
        check("pre_reset_ovf_c", 32'(ic.ovf), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        reset_models();
        check("async_reset_q_a", 32'(ia.q), 32'd0);
        check("async_reset_ovf_c", 32'(ic.ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_all();
        ia.en = 1;
        tick();
        check("post_reset_q_a", 32'(ia.q), 32'd1);

        // Wrap up through 9 -> 0.
        idle_all();
        ia.clr = 1; ia.ovf_clr = 1;
        tick();
        idle_all();
        ia.en = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("wrap_up_q_%0d", k), 32'(ia.q), 32'(k % 10));
            check($sformatf("wrap_up_ovf_%0d", k), 32'(ia.ovf), 32'(k >= 10));
            if (k == 9) check("wrap_up_tc_at_9", 32'(ia.tc), 32'd1);
        end

        // Wrap down from 0 -> 9.
        idle_all();
        ia.clr = 1; ia.ovf_clr = 1;
        tick();
        idle_all();
        ia.up = 0;
        #1;
        check("wrap_dn_tc_at_0", 32'(ia.tc), 32'd1);
        ia.en = 1;
        tick();
        check("wrap_dn_q", 32'(ia.q), 32'd9);
        check("wrap_dn_ovf", 32'(ia.ovf), 32'd1);

        // Saturate at 9, then set-wins and plain clear of ovf.
        idle_all();
        ib.load = 1; ib.load_val = 4'd8; ib.ovf_clr = 1;
        tick();
        idle_all();
        ib.en = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("sat_q_%0d", k), 32'(ib.q), 32'd9);
            check($sformatf("sat_ovf_%0d", k), 32'(ib.ovf), 32'(k >= 2));
        end
        ib.ovf_clr = 1;
        tick();
        check("sat_set_wins_ovf", 32'(ib.ovf), 32'd1);
        ib.en = 0;
        tick();
        check("sat_ovf_cleared", 32'(ib.ovf), 32'd0);

        // Priority and load clamp.
        idle_all();
        ia.clr = 1; ia.load = 1; ia.load_val = 4'd3;
        tick();
        check("prio_clr_over_load", 32'(ia.q), 32'd0);
        idle_all();
        ia.load = 1; ia.load_val = 4'd13; ia.ovf_clr = 1;
        tick();
        check("load_clamp", 32'(ia.q), 32'd9);
        idle_all();
        ia.load = 1; ia.load_val = 4'd4; ia.en = 1;
        tick();
        check("load_over_count_q", 32'(ia.q), 32'd4);
        check("load_masks_ovf", 32'(ia.ovf), 32'd0);

        // Full-range rollover on the 8-bit counter.
        idle_all();
        ic.load = 1; ic.load_val = 8'd255; ic.ovf_clr = 1;
        tick();
        idle_all();
        ic.en = 1;
        tick();
        check("full_roll_up_q", 32'(ic.q), 32'd0);
        check("full_roll_up_ovf", 32'(ic.ovf), 32'd1);
        idle_all();
        ic.ovf_clr = 1;
        tick();
        check("full_ovf_cleared", 32'(ic.ovf), 32'd0);
        idle_all();
        ic.up = 0; ic.en = 1;
        tick();
        check("full_roll_dn_q", 32'(ic.q), 32'd255);
        check("full_roll_dn_ovf", 32'(ic.ovf), 32'd1);

        // Random traffic on all three counters; direction changes rarely so limits get reached.
        idle_all();
        for (int n = 0; n < 600; n++) begin
            ia.clr = ($urandom_range(0, 15) == 0); ia.load = ($urandom_range(0, 7) == 0);
            ia.load_val = 4'($urandom); ia.en = ($urandom_range(0, 3) != 0);
            ia.ovf_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) ia.up = ~ia.up;
            ib.clr = ($urandom_range(0, 15) == 0); ib.load = ($urandom_range(0, 7) == 0);
            ib.load_val = 4'($urandom); ib.en = ($urandom_range(0, 3) != 0);
            ib.ovf_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) ib.up = ~ib.up;
            ic.clr = ($urandom_range(0, 63) == 0); ic.load = ($urandom_range(0, 15) == 0);
            ic.load_val = 8'($urandom); ic.en = ($urandom_range(0, 3) != 0);
            ic.ovf_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) ic.up = ~ic.up;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cn_counter.md
# cn_counter

Parametrised synchronous up/down counter built from per-bit CN cells (hold / clear / toggle / set). It is the multi-bit successor of the single-bit CN flip-flop. It adds configurable width and modulus, wrap or saturate mode, parallel load, direction control, a terminal-count flag and a sticky overflow flag. It sits in the datapath wherever timers, event counters or address sequencers are needed.

## Interface
- WIDTH, 8, counter width in bits (≥1)
- MODULUS, 2**WIDTH, count range is 0..MODULUS-1 (2 ≤ MODULUS ≤ 2**WIDTH)
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  reset; asynchronous assert, active-low
- clr  in  1  synchronous clear of count to 0
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value for load
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- ovf_clr  in  1  clears sticky ovf
- q  out  WIDTH  current count (registered)
- tc  out  1  terminal count: (up && q==MODULUS-1) || (!up && q==0)
- ovf  out  1  sticky overflow/underflow flag (registered)

## Operation
- Reset (rst_n=0, asynchronous): q=0, ovf=0 immediately; tc then follows q and up.
- Priority per cycle: clr > load > (en count) > hold.
- clr=1: q←0. ovf is unaffected.
- load=1 (clr=0): q←load_val. If load_val ≥ MODULUS, q←MODULUS-1 (clamp).
- en=1, up=1: if q<MODULUS-1, q←q+1. At q=MODULUS-1: wrap mode q←0, saturate mode q holds. Either way an overflow event occurs.
- en=1, up=0: if q>0, q←q-1. At q=0: wrap mode q←MODULUS-1, saturate mode q holds. Either way an underflow event occurs.
- en=0 with no clr/load: q holds.
- Per-bit cell control:
  - Increment: bit i toggles when bits 0..i-1 are all 1.
  - Decrement: bit i toggles when bits 0..i-1 are all 0.
  - Wrap to 0 uses clear ops; wrap to MODULUS-1 and load use set/clear per bit.
  - No adder is inferred for the count path.
- ovf is set on any overflow/underflow event, in both modes. ovf_clr=1 clears it. If set and ovf_clr coincide, set wins.
- Events only occur on count cycles. clr or load masks the event in the same cycle.
- tc is combinational from q and up. It is not gated by en.
- When MODULUS = 2**WIDTH, the natural binary rollover is the wrap. No extra decode is needed.

## Timing
- q and ovf update one cycle after the qualifying input edge: latency 1.
- tc is valid in the same cycle as q. It changes combinationally with up.
- Reset assertion mid-count forces q=0 and ovf=0 without waiting for clk.
- Reset deassertion is expected synchronous to clk. The first count occurs on the first posedge with rst_n=1.
- Direction change takes effect on the next count edge. There is no pipeline.

## Structure
- Shared package holds:
  - CN op encoding (HOLD=2'b00, CLEAR=2'b01, TOGGLE=2'b10, SET=2'b11).
  - A clog2-style width helper used for MODULUS checks.
- Sub-module cn_cell: one bit with an async active-low reset to 0. Inputs are a 2-bit op and clk; output is the bit. It is generated WIDTH times.
- The top level contains:
  - the toggle-condition chains (up and down),
  - the limit decode,
  - the clamp compare for load,
  - the op select per bit,
  - the ovf register.
- Parameter legality (MODULUS range) is checked at elaboration.

## Test plan
- Reset: drive rst_n=0 mid-count at q=5 between edges → q=0 and ovf=0 immediately; after release with en=1, up=1, q=1 after one edge.
- Wrap up (WIDTH=4, MODULUS=10, SATURATE=0): count from 0 for 12 edges → q sequence 1..9,0,1,2; tc=1 at q=9; ovf=1 from the edge after q=9.
- Wrap down (WIDTH=4, MODULUS=10): start at 0, up=0, en=1 → q=9 after one edge; ovf=1; tc=1 at q=0 before the edge.
- Saturate (WIDTH=4, MODULUS=10, SATURATE=1): count up from 8 for 3 edges → q=9,9,9; ovf=1 after the second edge. Then ovf_clr with en=1 at q=9 → ovf stays 1 (set wins). Then ovf_clr with en=0 → ovf=0.
- Priority and clamp: clr=1, load=1, load_val=3 → q=0. Then load=1, load_val=13 (MODULUS=10) → q=9. Then load=1, en=1 at q=9 → q=load_val; no ovf set.
- Full-range rollover (WIDTH=8, MODULUS=256): start at q=255, up=1, en=1 → q=0, ovf=1. Then, with ovf cleared and q=0, count down → q=255, ovf=1.
